// File: rtl/mem_io_pkg.sv
// ============================================================================
//  Module  : mem_io_pkg
//  Purpose : Shared types and constants for the data-memory responder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_io_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Byte offsets inside the I/O page
    localparam logic [3:0] KEYDATA_OFS = 4'h0;
    localparam logic [3:0] KEYSTAT_OFS = 4'h4;
    localparam logic [3:0] CYCLES_OFS  = 4'h8;
    localparam logic [3:0] LED_OFS     = 4'hC;

    localparam logic [31:0] DEF_DMEM_BASE = 32'h1001_0000;
    localparam logic [31:0] DEF_MMIO_BASE = 32'h1003_0000;

endpackage

`default_nettype wire

// File: rtl/key_fifo.sv
// ============================================================================
//  Module  : key_fifo
//  Purpose : Keyboard scan-code FIFO with sticky overflow flag.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module key_fifo #(
    parameter int KEYDEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clear_ovf,
    input  logic [7:0]                  din,
    output logic [7:0]                  head,
    output logic [$clog2(KEYDEPTH):0]   count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow
);
    localparam int c_AW = $clog2(KEYDEPTH);

    logic [7:0]      r_mem [KEYDEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_ovf;
    logic            w_do_pop;
    logic            w_do_push;

    assign empty    = (r_count == '0);
    assign full     = (r_count == (c_AW+1)'(KEYDEPTH));
    assign w_do_pop = pop && !empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO succeeds then
    assign w_do_push = push && (!full || w_do_pop);

    assign head     = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_ovf;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
            // A fresh overflow outranks a status-read clear
            if (push && !w_do_push) r_ovf <= 1'b1;
            else if (clear_ovf)     r_ovf <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_io_responder.sv
// ============================================================================
//  Module  : mem_io_responder
//  Purpose : Data-memory responder: synchronous RAM with one-cycle load stall
//            plus an I/O page (key FIFO, cycle counter, LED register).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int          Nloc      = 64,
    parameter int          Dbits     = 32,
    parameter int          KEYDEPTH  = 4,
    parameter logic [31:0] DMEM_BASE = DEF_DMEM_BASE,
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      mem_addr,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [Dbits-1:0] mem_writedata,
    output logic [Dbits-1:0] mem_readdata,
    output logic             cpu_enable,
    input  logic             key_valid,
    input  logic [7:0]       key_code,
    output logic [15:0]      led
);
    localparam int c_AW = $clog2(Nloc);
    localparam int c_CW = $clog2(KEYDEPTH) + 1;

    logic [Dbits-1:0] r_ram [Nloc];
    logic [Dbits-1:0] r_ram_word;
    logic [Dbits-1:0] r_cycles;
    logic [15:0]      r_led;
    state_t           r_state;

    logic [31:0]      w_ram_off;
    logic             w_ram_hit;
    logic [c_AW-1:0]  w_ram_idx;
    logic             w_io_hit;
    logic [3:0]       w_io_ofs;
    logic             w_stall;
    logic             w_io_rd;
    logic [Dbits-1:0] w_keystat;
    logic [7:0]       w_head;
    logic [c_CW-1:0]  w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_ovf;
    logic             w_unused;

    // Offset compare also rejects addresses below the base (they wrap high)
    assign w_ram_off = mem_addr - DMEM_BASE;
    assign w_ram_hit = (w_ram_off < 32'(4 * Nloc));
    assign w_ram_idx = mem_addr[c_AW+1:2];
    assign w_io_hit  = (mem_addr[31:4] == MMIO_BASE[31:4]);
    assign w_io_ofs  = {mem_addr[3:2], 2'b00};
    assign w_unused  = ^{mem_addr[1:0], w_full};

    // Simultaneous rd/wr is treated as a write, so it never stalls
    assign w_stall    = (r_state == IDLE) && mem_rd && !mem_wr && w_ram_hit;
    assign cpu_enable = !w_stall;
    assign w_io_rd    = mem_rd && !mem_wr && w_io_hit && cpu_enable;
    assign led        = r_led;

    key_fifo #(.KEYDEPTH(KEYDEPTH)) u_key_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (key_valid),
        .pop       (w_io_rd && (w_io_ofs == KEYDATA_OFS)),
        .clear_ovf (w_io_rd && (w_io_ofs == KEYSTAT_OFS)),
        .din       (key_code),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty),
        .overflow  (w_ovf)
    );

    always_comb begin
        w_keystat             = '0;
        w_keystat[8]          = w_ovf;
        w_keystat[c_CW-1:0]   = w_count;
    end

    always_comb begin
        mem_readdata = '0;
        if (r_state == WAIT) begin
            mem_readdata = r_ram_word;
        end else if (mem_rd && w_io_hit) begin
            case (w_io_ofs)
                KEYDATA_OFS: mem_readdata = w_empty ? '0 : Dbits'(w_head);
                KEYSTAT_OFS: mem_readdata = w_keystat;
                CYCLES_OFS:  mem_readdata = r_cycles;
                LED_OFS:     mem_readdata = Dbits'(r_led);
                default:     mem_readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr && w_ram_hit && cpu_enable) begin
            r_ram[w_ram_idx] <= mem_writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ram_word <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_stall) begin
                        r_ram_word <= r_ram[w_ram_idx];
                        r_state    <= WAIT;
                    end
                end
                WAIT:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
            r_led    <= '0;
        end else begin
            if (mem_wr && cpu_enable && w_io_hit && (w_io_ofs == CYCLES_OFS))
                r_cycles <= mem_writedata;
            else
                r_cycles <= r_cycles + 1'b1;
            if (mem_wr && cpu_enable && w_io_hit && (w_io_ofs == LED_OFS))
                r_led <= mem_writedata[15:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// ============================================================================
//  Module  : tb_mem_io_responder
//  Purpose : Directed scoreboard bench for mem_io_responder.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_io_responder;

    localparam logic [31:0] c_KEYDATA = 32'h1003_0000;
    localparam logic [31:0] c_KEYSTAT = 32'h1003_0004;
    localparam logic [31:0] c_CYCLES  = 32'h1003_0008;
    localparam logic [31:0] c_LED     = 32'h1003_000C;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        cpu_enable;
    logic        key_valid;
    logic [7:0]  key_code;
    logic [15:0] led;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    mem_io_responder dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .cpu_enable    (cpu_enable),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .led           (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: a load completes at any cycle where it is not stalled
    always @(negedge clk) begin
        if (!reset && mem_rd && cpu_enable) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_read: got %h with empty scoreboard", mem_readdata);
            end else begin
                check(name_q.pop_front(), mem_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic do_read(input string nm, input logic [31:0] a,
                           input logic [31:0] e, input int exp_stalls);
        int stalls = 0;
        bit done   = 0;
        mem_addr = a;
        mem_rd   = 1'b1;
        name_q.push_back(nm);
        exp_q.push_back(e);
        for (int i = 0; i < 4 && !done; i++) begin
            @(negedge clk);
            if (cpu_enable) done = 1;
            else stalls++;
        end
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: cpu_enable low for %0d cycles, required high", nm, stalls);
        end
        check({nm, "_stall"}, 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1;
        mem_rd = 1'b0;
    endtask

    task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] d);
        mem_addr      = a;
        mem_writedata = d;
        mem_wr        = 1'b1;
        @(negedge clk);
        check({nm, "_nostall"}, {31'b0, cpu_enable}, 32'd1);
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] c);
        key_code  = c;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
        mem_writedata = '0; key_valid = 1'b0; key_code = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_enable", {31'b0, cpu_enable}, 32'd1);
        check("rst_led", {16'b0, led}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_read("rst_cycles", c_CYCLES, 32'd0, 0);
        do_read("rst_keystat", c_KEYSTAT, 32'd0, 0);

        // RAM write/read with one-cycle stall
        do_write("wr_08", 32'h1001_0008, 32'hDEAD_BEEF);
        do_read("rd_08", 32'h1001_0008, 32'hDEAD_BEEF, 1);
        do_write("wr_00", 32'h1001_0000, 32'd1);
        do_write("wr_04", 32'h1001_0004, 32'd2);
        do_read("rd_00", 32'h1001_0000, 32'd1, 1);
        do_read("rd_04", 32'h1001_0004, 32'd2, 1);
        do_write("wr_last", 32'h1001_00FC, 32'h5A5A_0001);
        do_read("rd_last", 32'h1001_00FF, 32'h5A5A_0001, 1);
        do_read("rd_past_end", 32'h1001_0100, 32'd0, 0);
        do_read("rd_below", 32'h1000_FFFC, 32'd0, 0);

        // Key FIFO basic
        push_key(8'h1C);
        push_key(8'h32);
        do_read("ks_two", c_KEYSTAT, 32'd2, 0);
        do_read("kd_1c", c_KEYDATA, 32'h1C, 0);
        do_read("kd_32", c_KEYDATA, 32'h32, 0);
        do_read("ks_zero", c_KEYSTAT, 32'd0, 0);
        do_read("kd_empty", c_KEYDATA, 32'd0, 0);
        do_read("ks_still0", c_KEYSTAT, 32'd0, 0);

        // Push together with a read while empty: push only
        key_code = 8'h55; key_valid = 1'b1;
        do_read("kd_empty_push", c_KEYDATA, 32'd0, 0);
        key_valid = 1'b0;
        do_read("ks_one", c_KEYSTAT, 32'd1, 0);
        do_read("kd_55", c_KEYDATA, 32'h55, 0);

        // Overflow and push+pop while full
        for (int i = 1; i <= 5; i++) push_key(8'hA0 + 8'(i));
        do_read("ks_ovf", c_KEYSTAT, 32'h104, 0);
        do_read("ks_ovf_clr", c_KEYSTAT, 32'h004, 0);
        key_code = 8'hA6; key_valid = 1'b1;
        do_read("kd_full_pp", c_KEYDATA, 32'hA1, 0);
        key_valid = 1'b0;
        do_read("ks_full_pp", c_KEYSTAT, 32'h004, 0);
        do_read("kd_a2", c_KEYDATA, 32'hA2, 0);
        do_read("kd_a3", c_KEYDATA, 32'hA3, 0);
        do_read("kd_a4", c_KEYDATA, 32'hA4, 0);
        do_read("kd_a6", c_KEYDATA, 32'hA6, 0);
        do_read("ks_drained", c_KEYSTAT, 32'd0, 0);

        // Cycle counter, LED, unmapped
        do_write("wr_cycles", c_CYCLES, 32'h10);
        @(posedge clk);
        #1;
        do_read("rd_cycles", c_CYCLES, 32'h11, 0);
        do_write("wr_led", c_LED, 32'hFFFF_ABCD);
        check("led_out", {16'b0, led}, 32'h0000_ABCD);
        do_read("rd_led", c_LED, 32'h0000_ABCD, 0);
        do_write("wr_unmapped", 32'h1002_0000, 32'h1234_5678);
        do_read("rd_unmapped", 32'h1002_0000, 32'd0, 0);

        // Reset asserted while in WAIT
        mem_addr = 32'h1001_0008;
        mem_rd   = 1'b1;
        @(negedge clk);
        check("wait_stall", {31'b0, cpu_enable}, 32'd0);
        @(posedge clk);
        #2;
        check("wait_enable", {31'b0, cpu_enable}, 32'd1);
        check("wait_data", mem_readdata, 32'hDEAD_BEEF);
        reset  = 1'b1;
        mem_rd = 1'b0;
        #1;
        check("arst_enable", {31'b0, cpu_enable}, 32'd1);
        check("arst_led", {16'b0, led}, 32'd0);
        check("arst_data", mem_readdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        do_read("arst_cycles", c_CYCLES, 32'd0, 0);
        mem_addr = 32'd0;
        @(negedge clk);
        check("idle_data", mem_readdata, 32'd0);
        @(posedge clk);
        #1;
        do_read("rd_after_rst", 32'h1001_0008, 32'hDEAD_BEEF, 1);

        @(posedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
